// File: rtl/ppu_pkg.sv
// ppu_pkg: shared PPU types, plus the add-scheduler pipeline entry and its normalize step.
package ppu_pkg;

    localparam int PPU_TE_BITS      = 12;
    localparam int ADD_SCHED_MANT_W = 30;
    localparam int ADD_SCHED_ID_W   = 2;
    localparam int ADD_SCHED_STAT_W = 32;

    typedef logic [PPU_TE_BITS-1:0] exponent_t;

    typedef struct packed {
        logic [ADD_SCHED_ID_W-1:0]   id;
        logic [ADD_SCHED_MANT_W-1:0] mant;
        exponent_t                   te;
        logic                        trunc;
    } add_sched_entry_t;

    // A carry out of the mantissa sum costs one bit of precision and one exponent step.
    function automatic add_sched_entry_t add_sched_normalize(
        input logic [ADD_SCHED_ID_W-1:0]   id,
        input logic [ADD_SCHED_MANT_W-1:0] mant,
        input exponent_t                   te
    );
        add_sched_entry_t e;
        e.id = id;
        if (mant[ADD_SCHED_MANT_W-1]) begin
            e.mant  = mant >> 1;
            e.te    = te + exponent_t'(1);
            e.trunc = mant[0];
        end else begin
            e.mant  = mant;
            e.te    = te;
            e.trunc = 1'b0;
        end
        return e;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; priority starts just after the last granted index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_reg;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] cand;

    // Scan farthest-to-nearest so the nearest valid requester overrides earlier hits.
    always_comb begin
        gnt     = '0;
        gnt_idx = last_reg;
        cand    = '0;
        for (int i = N; i >= 1; i--) begin
            cand = IW'((32'(last_reg) + 32'(i)) % 32'(N));
            if (req[cand]) begin
                gnt_idx = cand;
            end
        end
        if (|req) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_reg <= IW'(N - 1);
        end else if (en && |req) begin
            last_reg <= gnt_idx;
        end
    end

endmodule

// File: rtl/ppu_add_sched.sv
// ppu_add_sched: shares one carry normalizer among N_REQ adders via a 2-stage valid/ready pipe.
// Optional grant/stall counters are built when PPU_ADD_SCHED_STATS_EN is defined.
module ppu_add_sched
    import ppu_pkg::*;
#(
    parameter int N_REQ                = 4,
    parameter int TE_BITS              = PPU_TE_BITS,
    parameter int MANT_ADD_RESULT_SIZE = ADD_SCHED_MANT_W
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [N_REQ-1:0]                       req_valid_i,
    output logic [N_REQ-1:0]                       req_ready_o,
    input  logic [N_REQ*MANT_ADD_RESULT_SIZE-1:0]  req_mant_i,
    input  logic [N_REQ*TE_BITS-1:0]               req_te_i,
    output logic                                   rsp_valid_o,
    input  logic                                   rsp_ready_i,
    output logic [$clog2(N_REQ)-1:0]               rsp_id_o,
    output logic [MANT_ADD_RESULT_SIZE-1:0]        rsp_mant_o,
    output exponent_t                              rsp_te_o,
    output logic                                   rsp_trunc_o
`ifdef PPU_ADD_SCHED_STATS_EN
    ,
    input  logic [$clog2(N_REQ):0]                 stat_sel_i,
    output logic [ADD_SCHED_STAT_W-1:0]            stat_o
`endif
);

    localparam int ID_W = $clog2(N_REQ);

    logic [MANT_ADD_RESULT_SIZE-1:0] mant_arr [N_REQ];
    exponent_t                       te_arr   [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign mant_arr[gi] = req_mant_i[gi*MANT_ADD_RESULT_SIZE +: MANT_ADD_RESULT_SIZE];
            assign te_arr[gi]   = req_te_i[gi*TE_BITS +: TE_BITS];
        end
    endgenerate

    logic                            a_valid_reg;
    logic [ID_W-1:0]                 a_id_reg;
    logic [MANT_ADD_RESULT_SIZE-1:0] a_mant_reg;
    exponent_t                       a_te_reg;
    logic                            b_valid_reg;
    add_sched_entry_t                b_entry_reg;
    add_sched_entry_t                b_entry_next;

    logic                            b_load;
    logic                            a_accept;
    logic                            xfer;
    logic [N_REQ-1:0]                gnt;
    logic [ID_W-1:0]                 sel_id;
    logic [MANT_ADD_RESULT_SIZE-1:0] sel_mant;
    exponent_t                       sel_te;

    assign b_load   = a_valid_reg && (!b_valid_reg || rsp_ready_i);
    assign a_accept = (!a_valid_reg || b_load) && !rst_i;
    assign xfer     = a_accept && |req_valid_i;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req   (req_valid_i),
        .en    (a_accept),
        .gnt   (gnt)
    );

    assign req_ready_o = a_accept ? gnt : '0;

    // Grant is one-hot, so an AND-OR mux picks the winner's payload.
    always_comb begin
        sel_id   = '0;
        sel_mant = '0;
        sel_te   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                sel_id   = sel_id | ID_W'(k);
                sel_mant = sel_mant | mant_arr[k];
                sel_te   = sel_te | te_arr[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_valid_reg <= 1'b0;
            a_id_reg    <= '0;
            a_mant_reg  <= '0;
            a_te_reg    <= '0;
        end else if (a_accept) begin
            a_valid_reg <= xfer;
            if (xfer) begin
                a_id_reg   <= sel_id;
                a_mant_reg <= sel_mant;
                a_te_reg   <= sel_te;
            end
        end
    end

    assign b_entry_next = add_sched_normalize(a_id_reg, a_mant_reg, a_te_reg);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            b_valid_reg <= 1'b0;
            b_entry_reg <= '0;
        end else if (b_load) begin
            b_valid_reg <= 1'b1;
            b_entry_reg <= b_entry_next;
        end else if (rsp_ready_i) begin
            b_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid_o = b_valid_reg;
    assign rsp_id_o    = b_entry_reg.id;
    assign rsp_mant_o  = b_entry_reg.mant;
    assign rsp_te_o    = b_entry_reg.te;
    assign rsp_trunc_o = b_entry_reg.trunc;

`ifdef PPU_ADD_SCHED_STATS_EN
    logic [ADD_SCHED_STAT_W-1:0] gnt_cnt_arr [N_REQ];
    logic [ADD_SCHED_STAT_W-1:0] stall_cnt_reg;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt_cnt
            logic [ADD_SCHED_STAT_W-1:0] cnt_reg;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_reg <= '0;
                end else if (req_valid_i[gi] && req_ready_o[gi]) begin
                    cnt_reg <= cnt_reg + ADD_SCHED_STAT_W'(1);
                end
            end
            assign gnt_cnt_arr[gi] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
        end else if (rsp_valid_o && !rsp_ready_i) begin
            stall_cnt_reg <= stall_cnt_reg + ADD_SCHED_STAT_W'(1);
        end
    end

    always_comb begin
        stat_o = '0;
        if (32'(stat_sel_i) < 32'(N_REQ)) begin
            stat_o = gnt_cnt_arr[stat_sel_i[ID_W-1:0]];
        end else if (32'(stat_sel_i) == 32'(N_REQ)) begin
            stat_o = stall_cnt_reg;
        end
    end
`endif

endmodule

// File: tb/tb_ppu_add_sched.sv
// tb_ppu_add_sched: directed stimulus checked each cycle against a queue-based model of the scheduler.
module tb_ppu_add_sched;

    localparam int N  = 4;
    localparam int MW = 30;
    localparam int TW = 12;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*MW-1:0] req_mant;
    logic [N*TW-1:0] req_te;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [MW-1:0]   rsp_mant;
    logic [TW-1:0]   rsp_te;
    logic            rsp_trunc;
`ifdef PPU_ADD_SCHED_STATS_EN
    logic [2:0]      stat_sel;
    logic [31:0]     stat;
`endif

    always #5 clk = ~clk;

    ppu_add_sched dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_mant_i  (req_mant),
        .req_te_i    (req_te),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_mant_o  (rsp_mant),
        .rsp_te_o    (rsp_te),
        .rsp_trunc_o (rsp_trunc)
`ifdef PPU_ADD_SCHED_STATS_EN
        ,
        .stat_sel_i  (stat_sel),
        .stat_o      (stat)
`endif
    );

    typedef struct {
        int          id;
        logic [29:0] mant;
        logic [11:0] te;
        logic        trunc;
        int          born;
    } ent_t;

    ent_t q[$];
    ent_t rlog[$];
    int   glog[$];
    int   checks = 0;
    int   errors = 0;
    int   last_m = N - 1;
    int   cyc = 0;
    logic rst_q = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ent_t norm(input int id, input logic [29:0] m, input logic [11:0] t, input int born);
        ent_t e;
        e.id   = id;
        e.born = born;
        if (m >= 30'h2000_0000) begin
            e.mant  = m / 2;
            e.te    = 12'((int'(t) + 1) % 4096);
            e.trunc = 1'(m % 2);
        end else begin
            e.mant  = m;
            e.te    = t;
            e.trunc = 1'b0;
        end
        return e;
    endfunction

    task automatic set_req(input int k, input logic [29:0] m, input logic [11:0] t);
        req_mant[k*MW +: MW] = m;
        req_te[k*TW +: TW]   = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) rst_q <= rst_i;

    // Model: at most two entries in flight; the oldest is visible two cycles after its grant.
    int       m_g;
    int       m_k;
    bit       m_acc;
    bit       m_ev;
    logic [3:0] m_gnt;
    always @(negedge clk) begin
        if (rst_i) begin
            chk("ready_in_reset", 64'(req_ready), 64'(0));
            if (rst_q) begin
                chk("rst_valid", 64'(rsp_valid), 64'(0));
                chk("rst_id", 64'(rsp_id), 64'(0));
                chk("rst_mant", 64'(rsp_mant), 64'(0));
                chk("rst_te", 64'(rsp_te), 64'(0));
                chk("rst_trunc", 64'(rsp_trunc), 64'(0));
            end
            q.delete();
            last_m = N - 1;
            cyc    = 0;
        end else begin
            m_acc = (q.size() < 2) || rsp_ready;
            m_g   = -1;
            if (m_acc) begin
                for (int i = 1; i <= N; i++) begin
                    m_k = (last_m + i) % N;
                    if (m_g < 0 && req_valid[m_k]) m_g = m_k;
                end
            end
            m_gnt = '0;
            if (m_g >= 0) m_gnt[m_g] = 1'b1;
            chk("grant", 64'(req_ready), 64'(m_gnt));
            m_ev = (q.size() > 0) && (q[0].born <= cyc - 2);
            chk("rsp_valid", 64'(rsp_valid), 64'(m_ev));
            if (m_ev) begin
                chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
                chk("rsp_mant", 64'(rsp_mant), 64'(q[0].mant));
                chk("rsp_te", 64'(rsp_te), 64'(q[0].te));
                chk("rsp_trunc", 64'(rsp_trunc), 64'(q[0].trunc));
                if (rsp_ready) begin
                    $display("rsp id=%0d mant=%h te=%h trunc=%0b", rsp_id, rsp_mant, rsp_te, rsp_trunc);
                    rlog.push_back(q[0]);
                    void'(q.pop_front());
                end
            end
            if (m_g >= 0) begin
                q.push_back(norm(m_g, req_mant[m_g*MW +: MW], req_te[m_g*TW +: TW], cyc));
                glog.push_back(m_g);
                last_m = m_g;
            end
            cyc++;
        end
    end

    int base;
    int g0;

    initial begin
        rst_i     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        req_mant  = '0;
        req_te    = '0;
`ifdef PPU_ADD_SCHED_STATS_EN
        stat_sel  = '0;
`endif
        set_req(0, 30'h2000_0001, 12'd0);
        set_req(1, 30'h0ABC_0000, 12'd100);
        set_req(2, 30'h3FFF_FFFE, 12'd200);
        set_req(3, 30'h1234_5678, 12'd300);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Fairness: all requesters valid for 8 cycles, then 3 stall cycles.
        repeat (8) tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        rsp_ready = 1'b1;
`ifdef PPU_ADD_SCHED_STATS_EN
        for (int s = 0; s < 6; s++) begin
            stat_sel = 3'(s);
            #1;
            chk("stat_read", 64'(stat), (s < 4) ? 64'(2) : ((s == 4) ? 64'(3) : 64'(0)));
        end
`endif
        repeat (3) tick();
        chk("fair_grant_count", 64'(glog.size()), 64'(8));
        chk("fair_rsp_count", 64'(rlog.size()), 64'(8));
        if (glog.size() >= 8 && rlog.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("fair_grant_order", 64'(glog[i]), 64'(i % 4));
                chk("fair_rsp_order", 64'(rlog[i].id), 64'(i % 4));
            end
            chk("fair_r0_mant", 64'(rlog[0].mant), 64'(30'h1000_0000));
            chk("fair_r0_te", 64'(rlog[0].te), 64'(1));
            chk("fair_r0_trunc", 64'(rlog[0].trunc), 64'(1));
            chk("fair_r3_mant", 64'(rlog[3].mant), 64'(30'h1234_5678));
            chk("fair_r3_te", 64'(rlog[3].te), 64'(300));
        end

        // Carry normalize, pass-through and exponent wrap on requester 2.
        base = rlog.size();
        req_valid = 4'b0100;
        set_req(2, 30'h2000_0003, 12'd5);
        tick();
        set_req(2, 30'h1000_0002, 12'd5);
        tick();
        set_req(2, 30'h2000_0000, 12'hFFF);
        tick();
        req_valid = '0;
        repeat (3) tick();
        chk("carry_rsp_count", 64'(rlog.size() - base), 64'(3));
        if (rlog.size() >= base + 3) begin
            chk("carry_id", 64'(rlog[base].id), 64'(2));
            chk("carry_mant", 64'(rlog[base].mant), 64'(30'h1000_0001));
            chk("carry_te", 64'(rlog[base].te), 64'(6));
            chk("carry_trunc", 64'(rlog[base].trunc), 64'(1));
            chk("nocarry_mant", 64'(rlog[base+1].mant), 64'(30'h1000_0002));
            chk("nocarry_te", 64'(rlog[base+1].te), 64'(5));
            chk("nocarry_trunc", 64'(rlog[base+1].trunc), 64'(0));
            chk("wrap_mant", 64'(rlog[base+2].mant), 64'(30'h1000_0000));
            chk("wrap_te", 64'(rlog[base+2].te), 64'(0));
            chk("wrap_trunc", 64'(rlog[base+2].trunc), 64'(0));
        end

        // Lone requester held valid is granted every cycle.
        g0 = glog.size();
        req_valid = 4'b1000;
        repeat (4) tick();
        req_valid = '0;
        repeat (3) tick();
        chk("single_grants", 64'(glog.size() - g0), 64'(4));
        for (int i = g0; i < glog.size(); i++) chk("single_id", 64'(glog[i]), 64'(3));

        // Backpressure: only two grants fit, then release grants in the same cycle.
        base = rlog.size();
        g0   = glog.size();
        set_req(0, 30'h3000_0005, 12'h010);
        set_req(1, 30'h0000_0007, 12'h020);
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        repeat (5) tick();
        chk("bp_grants", 64'(glog.size() - g0), 64'(2));
        rsp_ready = 1'b1;
        #1;
        chk("bp_same_cycle_grant", 64'(req_ready), 64'(4'b0001));
        tick();
        repeat (3) tick();
        req_valid = '0;
        repeat (4) tick();
        chk("no_loss", 64'(rlog.size()), 64'(glog.size()));
        if (rlog.size() > base) begin
            chk("bp_first_id", 64'(rlog[base].id), 64'(0));
            chk("bp_first_mant", 64'(rlog[base].mant), 64'(30'h1800_0002));
            chk("bp_first_te", 64'(rlog[base].te), 64'(12'h011));
            chk("bp_first_trunc", 64'(rlog[base].trunc), 64'(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
